// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a single-outstanding data bus, checks alignment,
// aborts on a wait-cycle timeout and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  WB,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] ALU_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  RegDst_address,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [1:0]  _WB,
  output logic [31:0] _read_data,
  output logic [31:0] _ALU_result,
  output logic [4:0]  _RegDst_address,
  output logic        mem_exception,
  output logic        bus_error
);

  typedef enum logic {StIdle, StBus} state_e;

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_wb;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_is_load;

  logic        w_mem_op;
  logic        w_misalign;
  logic        w_fault;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem_op   = mem_read | mem_write;
  assign w_misalign = ((mem_size == 2'b01) & ALU_result[0]) |
                      ((mem_size == 2'b10) & (|ALU_result[1:0]));
  assign w_fault    = w_mem_op & (w_misalign | (mem_size == 2'b11) | (mem_read & mem_write));
  assign w_start    = w_mem_op & ~w_fault;
  assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));

  // Stall is gated by reset so upstream never freezes while the stage is held in reset.
  assign stall = reset_n & (((r_state == StIdle) & w_start) | ((r_state == StBus) & ~bus_ack));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data;
    unique case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << ALU_result[1:0];
        w_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = bus_rdata[{r_alu[1:0], 3'b000} +: 8];
  assign w_half = r_alu[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load = bus_rdata;
    unique case (r_size)
      2'b00:   w_load = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_cnt           <= 8'd0;
      r_wb            <= 2'b0;
      r_alu           <= 32'b0;
      r_rd            <= 5'b0;
      r_size          <= 2'b0;
      r_unsigned      <= 1'b0;
      r_is_load       <= 1'b0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= 32'b0;
      bus_be          <= 4'b0;
      bus_wdata       <= 32'b0;
      _WB             <= 2'b0;
      _read_data      <= 32'b0;
      _ALU_result     <= 32'b0;
      _RegDst_address <= 5'b0;
      mem_exception   <= 1'b0;
      bus_error       <= 1'b0;
    end else begin
      mem_exception <= 1'b0;
      bus_error     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state    <= StBus;
            r_cnt      <= 8'd0;
            r_wb       <= WB;
            r_alu      <= ALU_result;
            r_rd       <= RegDst_address;
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_is_load  <= mem_read;
            bus_req    <= 1'b1;
            bus_we     <= mem_write;
            bus_addr   <= {ALU_result[31:2], 2'b00};
            bus_be     <= w_be;
            bus_wdata  <= w_wdata;
            _WB        <= 2'b0;
          end else begin
            _WB             <= w_fault ? 2'b0 : WB;
            _ALU_result     <= ALU_result;
            _RegDst_address <= RegDst_address;
            _read_data      <= 32'b0;
            mem_exception   <= w_fault;
          end
        end
        StBus: begin
          if (bus_ack) begin
            r_state         <= StIdle;
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            _WB             <= r_wb;
            _ALU_result     <= r_alu;
            _RegDst_address <= r_rd;
            _read_data      <= r_is_load ? w_load : 32'b0;
          end else if (w_timeout) begin
            r_state   <= StIdle;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_error <= 1'b1;
            _WB       <= 2'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-lane arithmetic model.
module tb_mem_access_stage;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset_n;
  logic [1:0]  WB;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] ALU_result;
  logic [31:0] write_data;
  logic [4:0]  RegDst_address;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [1:0]  _WB;
  logic [31:0] _read_data;
  logic [31:0] _ALU_result;
  logic [4:0]  _RegDst_address;
  logic        mem_exception;
  logic        bus_error;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .WB              (WB),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_size        (mem_size),
    .mem_unsigned    (mem_unsigned),
    .ALU_result      (ALU_result),
    .write_data      (write_data),
    .RegDst_address  (RegDst_address),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata),
    .stall           (stall),
    ._WB             (_WB),
    ._read_data      (_read_data),
    ._ALU_result     (_ALU_result),
    ._RegDst_address (_RegDst_address),
    .mem_exception   (mem_exception),
    .bus_error       (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: lane arithmetic on byte counts.
  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nbytes = 1 << size;
    int unsigned a = (addr % 4) / nbytes * nbytes;
    return 4'(((1 << nbytes) - 1) << a);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return 32'(wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return 32'(wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic uns, input logic [31:0] rdata);
    int unsigned nbytes = 1 << size;
    int unsigned sh = 8 * ((addr % 4) / nbytes * nbytes);
    logic [63:0] v;
    logic [63:0] span;
    span = 64'd1 << (8 * nbytes);
    v = 64'(rdata >> sh) % span;
    if (!uns && nbytes < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic drive_idle();
    WB = 2'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b0; mem_unsigned = 1'b0;
    ALU_result = 32'b0; write_data = 32'b0; RegDst_address = 5'b0; bus_ack = 1'b0;
    bus_rdata = 32'b0;
  endtask

  task automatic scramble_inputs();
    WB = 2'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    mem_size = 2'($urandom); mem_unsigned = 1'($urandom); ALU_result = $urandom;
    write_data = $urandom; RegDst_address = 5'($urandom);
  endtask

  // Non-memory op issued in IDLE; caller is at posedge+1.
  task automatic run_alu_op(input string name, input logic [1:0] wb, input logic [31:0] alu,
                            input logic [4:0] rdst, input logic ack);
    drive_idle();
    WB = wb; ALU_result = alu; RegDst_address = rdst; bus_ack = ack; bus_rdata = $urandom;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL %s stall got %b exp 0", name, stall); else n_pass++;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    n_checks++; if (_WB !== wb) $display("FAIL %s _WB got %b exp %b", name, _WB, wb); else n_pass++;
    n_checks++; if (_ALU_result !== alu) $display("FAIL %s _ALU_result got %h exp %h", name, _ALU_result, alu); else n_pass++;
    n_checks++; if (_RegDst_address !== rdst) $display("FAIL %s _RegDst got %0d exp %0d", name, _RegDst_address, rdst); else n_pass++;
    n_checks++; if (_read_data !== 32'b0) $display("FAIL %s _read_data got %h exp 0", name, _read_data); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL %s bus_req got %b exp 0", name, bus_req); else n_pass++;
    n_checks++; if (mem_exception !== 1'b0) $display("FAIL %s mem_exception got %b exp 0", name, mem_exception); else n_pass++;
  endtask

  // Memory op; bus acks after `delay` non-ack BUS cycles (delay >= TO means never).
  task automatic run_mem_op(input string name, input logic [1:0] wb, input logic rd,
                            input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] rdst, input int delay, input logic [31:0] rdata);
    bit legal;
    bit acked;
    int stalls;
    legal = (rd != wr) && (size != 2'd3) && ((addr % (1 << size)) == 0);
    drive_idle();
    WB = wb; mem_read = rd; mem_write = wr; mem_size = size; mem_unsigned = uns;
    ALU_result = addr; write_data = wd; RegDst_address = rdst;
    #1;
    n_checks++; if (stall !== legal) $display("FAIL %s idle stall got %b exp %b", name, stall, legal); else n_pass++;
    @(posedge clk); #1;
    if (!legal) begin
      n_checks++; if (mem_exception !== 1'b1) $display("FAIL %s mem_exception got %b exp 1", name, mem_exception); else n_pass++;
      n_checks++; if (bus_req !== 1'b0) $display("FAIL %s fault bus_req got %b exp 0", name, bus_req); else n_pass++;
      n_checks++; if (_WB !== 2'b0) $display("FAIL %s fault _WB got %b exp 0", name, _WB); else n_pass++;
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (mem_exception !== 1'b0) $display("FAIL %s mem_exception pulse got %b exp 0", name, mem_exception); else n_pass++;
      n_checks++; if (bus_req !== 1'b0) $display("FAIL %s post-fault bus_req got %b exp 0", name, bus_req); else n_pass++;
      return;
    end
    n_checks++; if (bus_req !== 1'b1) $display("FAIL %s bus_req got %b exp 1", name, bus_req); else n_pass++;
    n_checks++; if (bus_we !== wr) $display("FAIL %s bus_we got %b exp %b", name, bus_we, wr); else n_pass++;
    n_checks++; if (bus_addr !== (addr & 32'hFFFF_FFFC)) $display("FAIL %s bus_addr got %h exp %h", name, bus_addr, addr & 32'hFFFF_FFFC); else n_pass++;
    n_checks++; if (bus_be !== ref_be(size, addr)) $display("FAIL %s bus_be got %b exp %b", name, bus_be, ref_be(size, addr)); else n_pass++;
    n_checks++; if (bus_wdata !== ref_wdata(size, wd)) $display("FAIL %s bus_wdata got %h exp %h", name, bus_wdata, ref_wdata(size, wd)); else n_pass++;
    n_checks++; if (_WB !== 2'b0) $display("FAIL %s bubble _WB got %b exp 0", name, _WB); else n_pass++;
    stalls = 1;
    acked = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      scramble_inputs();
      bus_ack = (k == delay);
      bus_rdata = (k == delay) ? rdata : $urandom;
      #1;
      if (stall === 1'b1) stalls++;
      acked = (k == delay);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (acked) break;
    end
    n_checks++; if (bus_req !== 1'b0) $display("FAIL %s end bus_req got %b exp 0", name, bus_req); else n_pass++;
    n_checks++; if (stalls !== (acked ? 1 + delay : 1 + int'(TO))) $display("FAIL %s stall cycles got %0d exp %0d", name, stalls, acked ? 1 + delay : 1 + int'(TO)); else n_pass++;
    if (acked) begin
      n_checks++; if (_WB !== wb) $display("FAIL %s _WB got %b exp %b", name, _WB, wb); else n_pass++;
      n_checks++; if (_ALU_result !== addr) $display("FAIL %s _ALU_result got %h exp %h", name, _ALU_result, addr); else n_pass++;
      n_checks++; if (_RegDst_address !== rdst) $display("FAIL %s _RegDst got %0d exp %0d", name, _RegDst_address, rdst); else n_pass++;
      n_checks++; if (_read_data !== (rd ? ref_load(size, addr, uns, rdata) : 32'b0)) $display("FAIL %s _read_data got %h exp %h", name, _read_data, rd ? ref_load(size, addr, uns, rdata) : 32'b0); else n_pass++;
      n_checks++; if (bus_error !== 1'b0) $display("FAIL %s bus_error got %b exp 0", name, bus_error); else n_pass++;
    end else begin
      n_checks++; if (bus_error !== 1'b1) $display("FAIL %s bus_error got %b exp 1", name, bus_error); else n_pass++;
      n_checks++; if (_WB !== 2'b0) $display("FAIL %s timeout _WB got %b exp 0", name, _WB); else n_pass++;
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus_error !== 1'b0) $display("FAIL %s bus_error pulse got %b exp 0", name, bus_error); else n_pass++;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0; WB = 2'b11; mem_read = 1'b1; mem_size = 2'b10; ALU_result = 32'h40;
    #2;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset stall got %b exp 0", stall); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL reset bus_req got %b exp 0", bus_req); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (_WB !== 2'b0) $display("FAIL reset _WB got %b exp 0", _WB); else n_pass++;
    n_checks++; if (_ALU_result !== 32'b0) $display("FAIL reset _ALU_result got %h exp 0", _ALU_result); else n_pass++;
    n_checks++; if ({mem_exception, bus_error} !== 2'b0) $display("FAIL reset faults got %b exp 00", {mem_exception, bus_error}); else n_pass++;
    reset_n = 1'b1;
    drive_idle();
  endtask

  task automatic test_alu_op();
    run_alu_op("alu_op", 2'b10, 32'h1234, 5'd5, 1'b0);
  endtask

  task automatic test_idle_ack();
    run_alu_op("idle_ack", 2'b01, 32'hCAFE_0000, 5'd17, 1'b1);
  endtask

  task automatic test_load_byte();
    run_mem_op("lb_0x103", 2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 3, 32'h80AA_BBCC);
  endtask

  task automatic test_store_half();
    run_mem_op("sh_0x202", 2'b00, 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 5'd0, 1, 32'h0);
  endtask

  task automatic test_faults();
    run_mem_op("lw_misalign", 2'b11, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 0, 32'h0);
    run_mem_op("lh_misalign", 2'b11, 1'b1, 1'b0, 2'd1, 1'b1, 32'h33, 32'h0, 5'd3, 0, 32'h0);
    run_mem_op("size_11", 2'b11, 1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd3, 0, 32'h0);
    run_mem_op("rd_and_wr", 2'b11, 1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 5'd3, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_mem_op("lw_timeout", 2'b11, 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd9, 1000, 32'h0);
  endtask

  task automatic test_ack_at_timeout();
    run_mem_op("ack_at_expiry", 2'b10, 1'b1, 1'b0, 2'd1, 1'b1, 32'h46, 32'h0, 5'd4, int'(TO) - 1, 32'h9ABC_8765);
  endtask

  task automatic test_back_to_back();
    run_mem_op("b2b_lw", 2'b11, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd1, 0, 32'hDEAD_BEEF);
    run_mem_op("b2b_sb", 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h15, 32'h1234_56A5, 5'd0, 2, 32'h0);
    run_mem_op("b2b_lhu", 2'b01, 1'b1, 1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 5'd2, 0, 32'hF00D_1234);
  endtask

  task automatic test_reset_mid_bus();
    drive_idle();
    WB = 2'b11; mem_read = 1'b1; mem_size = 2'b10; ALU_result = 32'h80; RegDst_address = 5'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL mid_bus_reset bus_req got %b exp 0", bus_req); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL mid_bus_reset stall got %b exp 0", stall); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if ({mem_exception, bus_error} !== 2'b0) $display("FAIL mid_bus_reset faults got %b exp 00", {mem_exception, bus_error}); else n_pass++;
    reset_n = 1'b1;
    run_alu_op("post_reset_alu", 2'b10, 32'h5555_AAAA, 5'd21, 1'b0);
    n_checks++; if (bus_error !== 1'b0) $display("FAIL post_reset bus_error got %b exp 0", bus_error); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind = int'($urandom_range(0, 9));
      logic [31:0] addr = $urandom;
      int dly = int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) != 0) addr[1:0] = (kind % 2 == 0) ? 2'b00 : addr[1:0];
      if ($urandom_range(0, 15) == 0) dly = 100;
      if (kind == 0) begin
        run_alu_op("rand_alu", 2'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end else begin
        logic rd = 1'($urandom);
        logic wr = (kind == 9) ? 1'b1 : ~rd;
        run_mem_op("rand_mem", 2'($urandom), rd, wr, 2'($urandom), 1'($urandom), addr, $urandom,
                   5'($urandom), dly, $urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_idle_ack();
    test_load_byte();
    test_store_half();
    test_faults();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
